// File: rtl/rx_pattern_checker.sv
// Receive-side pattern checker for the SERDES loopback test: compares each 128-bit word
// against the selected pattern family, tracks lock and accumulates error/word statistics.
module rx_pattern_checker #(
    parameter int            LOCK_CNT      = 64,
    parameter int            UNLOCK_CNT    = 4,
    parameter logic [127:0]  CONST_PATTERN = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA,
    parameter int            CNT_W         = 32
) (
    input  logic             clk160,
    input  logic             FPGA_RESETn,
    input  logic [127:0]     rx_data,
    input  logic             rx_valid,
    input  logic [1:0]       sel,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             word_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t         state, next_state;
    logic [GW-1:0]  good_run, good_run_nxt;
    logic [BW-1:0]  bad_run, bad_run_nxt;

    logic [1:0]     sel_s1, sel_s2, sel_r;
    logic           mode_chg;

    logic [127:0]   prev_word;
    logic           hist_valid;
    logic [127:0]   err_vec;
    logic           chk;

    logic [127:0]   expected;
    logic [158:0]   prbs_ext;
    logic [7:0]     errbits;
    logic           err_now;
    logic [CNT_W:0] err_sum;

    // sel comes from a push-button toggle, so it is synchronised before use
    always_ff @(posedge clk160 or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            sel_s1 <= 2'd0;
            sel_s2 <= 2'd0;
            sel_r  <= 2'd0;
        end else begin
            sel_s1 <= sel;
            sel_s2 <= sel_s1;
            sel_r  <= sel_s2;
        end
    end

    assign mode_chg = (sel_s2 != sel_r);

    // PRBS window: index k holds stream bit k-31, so the taps j-31 and j-28 sit at k=j and k=j+3
    always_comb begin
        prbs_ext = {rx_data, prev_word[127:97]};
        case (sel_r)
            2'd0:    expected = prev_word + 128'd1;
            2'd1:    expected = prbs_ext[127:0] ^ prbs_ext[130:3];
            2'd2:    expected = CONST_PATTERN;
            default: expected = ~CONST_PATTERN;
        endcase
    end

    // a mode change drops the in-flight word and invalidates history
    always_ff @(posedge clk160 or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            prev_word  <= '0;
            hist_valid <= 1'b0;
            err_vec    <= '0;
            chk        <= 1'b0;
        end else if (mode_chg) begin
            hist_valid <= 1'b0;
            chk        <= 1'b0;
        end else if (rx_valid) begin
            prev_word  <= rx_data;
            hist_valid <= 1'b1;
            err_vec    <= hist_valid ? (expected ^ rx_data) : '0;
            chk        <= hist_valid;
        end else begin
            chk        <= 1'b0;
        end
    end

    always_comb begin
        errbits = 8'd0;
        for (int i = 0; i < 128; i++) begin
            errbits = errbits + {7'd0, err_vec[i]};
        end
    end

    assign err_now = |err_vec;

    always_ff @(posedge clk160 or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            state    <= HUNT;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            state    <= next_state;
            good_run <= good_run_nxt;
            bad_run  <= bad_run_nxt;
        end
    end

    always_comb begin
        next_state   = state;
        good_run_nxt = good_run;
        bad_run_nxt  = bad_run;
        if (mode_chg) begin
            next_state   = HUNT;
            good_run_nxt = '0;
            bad_run_nxt  = '0;
        end else if (chk) begin
            case (state)
                HUNT: begin
                    if (err_now) begin
                        good_run_nxt = '0;
                    end else if (good_run == GW'(LOCK_CNT - 1)) begin
                        next_state   = LOCKED;
                        good_run_nxt = '0;
                        bad_run_nxt  = '0;
                    end else begin
                        good_run_nxt = good_run + 1'b1;
                    end
                end
                default: begin
                    if (!err_now) begin
                        bad_run_nxt = '0;
                    end else if (bad_run == BW'(UNLOCK_CNT - 1)) begin
                        next_state   = HUNT;
                        good_run_nxt = '0;
                        bad_run_nxt  = '0;
                    end else begin
                        bad_run_nxt = bad_run + 1'b1;
                    end
                end
            endcase
        end
    end

    assign locked  = (state == LOCKED);
    assign err_sum = {1'b0, err_cnt} + {{(CNT_W - 7){1'b0}}, errbits};

    // statistics use the state before this edge's transition, so the unlocking word still counts
    always_ff @(posedge clk160 or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            word_err <= 1'b0;
            err_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (chk) begin
                word_err <= err_now;
            end
            if (clr_cnt) begin
                err_cnt  <= '0;
                word_cnt <= '0;
            end else if (chk && state == LOCKED) begin
                err_cnt  <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                if (word_cnt != '1) begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Directed self-checking bench for rx_pattern_checker; a second instance built with
// 8-bit counters covers saturation.
module tb_rx_pattern_checker;

    localparam logic [127:0] CP = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;

    logic         clk160 = 1'b0;
    logic         FPGA_RESETn;
    logic [127:0] rx_data;
    logic         rx_valid;
    logic [1:0]   sel;
    logic         clr_cnt;
    logic         locked, word_err;
    logic [31:0]  err_cnt, word_cnt;
    logic         locked8, word_err8;
    logic [7:0]   err_cnt8, word_cnt8;

    int checks = 0;
    int fails  = 0;
    logic [30:0]  sr;

    always #3 clk160 = ~clk160;

    rx_pattern_checker dut (
        .clk160(clk160), .FPGA_RESETn(FPGA_RESETn), .rx_data(rx_data), .rx_valid(rx_valid),
        .sel(sel), .clr_cnt(clr_cnt), .locked(locked), .word_err(word_err),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    rx_pattern_checker #(.CNT_W(8)) dut8 (
        .clk160(clk160), .FPGA_RESETn(FPGA_RESETn), .rx_data(rx_data), .rx_valid(rx_valid),
        .sel(sel), .clr_cnt(clr_cnt), .locked(locked8), .word_err(word_err8),
        .err_cnt(err_cnt8), .word_cnt(word_cnt8)
    );

    task automatic push(input logic [127:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk160);
        #1;
    endtask

    // idle cycles carry junk data that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rx_valid = 1'b0;
            @(posedge clk160);
            #1;
        end
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        idle(1);
        clr_cnt = 1'b0;
    endtask

    task automatic gen_prbs(output logic [127:0] w);
        logic nb;
        for (int i = 0; i < 128; i++) begin
            nb   = sr[30] ^ sr[27];
            w[i] = nb;
            sr   = {sr[29:0], nb};
        end
    endtask

    function automatic logic sbit(input logic [127:0] prev, input logic [127:0] cur, input int j);
        return (j >= 0) ? cur[j] : prev[128 + j];
    endfunction

    function automatic int prbs_errs(input logic [127:0] prev, input logic [127:0] cur);
        int e = 0;
        for (int j = 0; j < 128; j++) begin
            if (cur[j] != (sbit(prev, cur, j - 31) ^ sbit(prev, cur, j - 28))) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        FPGA_RESETn = 1'b0;
        rx_data = '0; rx_valid = 1'b0; sel = 2'd0; clr_cnt = 1'b0;
        #1;
        checks++; if (locked !== 1'b0)    begin fails++; $display("[TB] FAIL rst_locked: got %0b want 0", locked); end
        checks++; if (word_err !== 1'b0)  begin fails++; $display("[TB] FAIL rst_word_err: got %0b want 0", word_err); end
        checks++; if (err_cnt !== 32'd0)  begin fails++; $display("[TB] FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (word_cnt !== 32'd0) begin fails++; $display("[TB] FAIL rst_word_cnt: got %0d want 0", word_cnt); end
        repeat (3) @(posedge clk160);
        @(negedge clk160);
        FPGA_RESETn = 1'b1;
        @(posedge clk160);
        #1;
        idle(3);
    endtask

    task automatic test_counter();
        for (int k = 0; k < 64; k++) push(128'(k));
        idle(1);
        checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL cnt_prelock: got %0b want 0", locked); end
        push(128'd64);
        idle(1);
        checks++; if (locked !== 1'b1)    begin fails++; $display("[TB] FAIL cnt_lock: got %0b want 1", locked); end
        checks++; if (word_cnt !== 32'd0) begin fails++; $display("[TB] FAIL cnt_lock_words: got %0d want 0", word_cnt); end
        for (int k = 65; k < 200; k++) push(128'(k));
        idle(1);
        checks++; if (word_cnt !== 32'd135) begin fails++; $display("[TB] FAIL cnt_words: got %0d want 135", word_cnt); end
        checks++; if (err_cnt !== 32'd0)    begin fails++; $display("[TB] FAIL cnt_errs: got %0d want 0", err_cnt); end
        checks++; if (word_err !== 1'b0)    begin fails++; $display("[TB] FAIL cnt_word_err: got %0b want 0", word_err); end
    endtask

    task automatic test_counter_wrap();
        logic [127:0] ones;
        ones = '1;
        clear_counters();
        push(ones - 128'd1);
        idle(1);
        checks++; if (word_err !== 1'b1)   begin fails++; $display("[TB] FAIL wrap_jump_err: got %0b want 1", word_err); end
        checks++; if (err_cnt !== 32'd124) begin fails++; $display("[TB] FAIL wrap_jump_bits: got %0d want 124", err_cnt); end
        push(ones);
        push(128'd0);
        push(128'd1);
        idle(1);
        checks++; if (word_err !== 1'b0)   begin fails++; $display("[TB] FAIL wrap_word_err: got %0b want 0", word_err); end
        checks++; if (err_cnt !== 32'd124) begin fails++; $display("[TB] FAIL wrap_errs: got %0d want 124", err_cnt); end
        checks++; if (word_cnt !== 32'd4)  begin fails++; $display("[TB] FAIL wrap_words: got %0d want 4", word_cnt); end
        checks++; if (locked !== 1'b1)     begin fails++; $display("[TB] FAIL wrap_locked: got %0b want 1", locked); end
    endtask

    task automatic test_prbs();
        logic [127:0] w, prev;
        int exp_err;
        exp_err = -1;
        sel = 2'd1;
        idle(4);
        sr = 31'h7FFF_FFFF;
        for (int k = 1; k <= 65; k++) begin
            gen_prbs(w);
            push(w);
            prev = w;
        end
        idle(1);
        checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL prbs_lock: got %0b want 1", locked); end
        clear_counters();
        for (int k = 66; k <= 100; k++) begin
            gen_prbs(w);
            if (k == 81) begin
                w[3]    = ~w[3];
                w[77]   = ~w[77];
                exp_err = prbs_errs(prev, w);
            end
            push(w);
            prev = w;
            if (k == 82) begin
                checks++; if (word_err !== 1'b1) begin fails++; $display("[TB] FAIL prbs_hit: got %0b want 1", word_err); end
            end
            if (k == 83) begin
                checks++; if (word_err !== 1'b0) begin fails++; $display("[TB] FAIL prbs_recover: got %0b want 0", word_err); end
            end
        end
        idle(1);
        checks++; if (err_cnt !== 32'(exp_err)) begin fails++; $display("[TB] FAIL prbs_model_errs: got %0d want %0d", err_cnt, exp_err); end
        checks++; if (err_cnt !== 32'd6)        begin fails++; $display("[TB] FAIL prbs_errs: got %0d want 6", err_cnt); end
        checks++; if (word_cnt !== 32'd35)      begin fails++; $display("[TB] FAIL prbs_words: got %0d want 35", word_cnt); end
        checks++; if (locked !== 1'b1)          begin fails++; $display("[TB] FAIL prbs_still_locked: got %0b want 1", locked); end
    endtask

    task automatic test_mode_switch();
        sel = 2'd3;
        idle(2);
        checks++; if (locked !== 1'b1) begin fails++; $display("[TB] FAIL sw_sync_hold: got %0b want 1", locked); end
        idle(1);
        checks++; if (locked !== 1'b0)     begin fails++; $display("[TB] FAIL sw_unlock: got %0b want 0", locked); end
        checks++; if (err_cnt !== 32'd6)   begin fails++; $display("[TB] FAIL sw_keep_errs: got %0d want 6", err_cnt); end
        checks++; if (word_cnt !== 32'd35) begin fails++; $display("[TB] FAIL sw_keep_words: got %0d want 35", word_cnt); end
        for (int k = 0; k < 64; k++) push(~CP);
        idle(1);
        checks++; if (locked !== 1'b0) begin fails++; $display("[TB] FAIL sw_prelock: got %0b want 0", locked); end
        push(~CP);
        idle(1);
        checks++; if (locked !== 1'b1)     begin fails++; $display("[TB] FAIL sw_relock: got %0b want 1", locked); end
        checks++; if (word_cnt !== 32'd35) begin fails++; $display("[TB] FAIL sw_relock_words: got %0d want 35", word_cnt); end
    endtask

    task automatic test_const();
        sel = 2'd2;
        idle(4);
        clear_counters();
        for (int k = 0; k < 65; k++) push(CP);
        idle(1);
        checks++; if (locked !== 1'b1)    begin fails++; $display("[TB] FAIL const_lock: got %0b want 1", locked); end
        checks++; if (word_cnt !== 32'd0) begin fails++; $display("[TB] FAIL const_lock_words: got %0d want 0", word_cnt); end
        for (int k = 0; k < 3; k++) push(128'd0);
        idle(1);
        checks++; if (locked !== 1'b1)     begin fails++; $display("[TB] FAIL const_3bad_locked: got %0b want 1", locked); end
        checks++; if (err_cnt !== 32'd192) begin fails++; $display("[TB] FAIL const_3bad_errs: got %0d want 192", err_cnt); end
        push(128'd0);
        idle(1);
        checks++; if (locked !== 1'b0)     begin fails++; $display("[TB] FAIL const_unlock: got %0b want 0", locked); end
        checks++; if (err_cnt !== 32'd256) begin fails++; $display("[TB] FAIL const_errs: got %0d want 256", err_cnt); end
        checks++; if (word_cnt !== 32'd4)  begin fails++; $display("[TB] FAIL const_words: got %0d want 4", word_cnt); end
        checks++; if (word_err !== 1'b1)   begin fails++; $display("[TB] FAIL const_word_err: got %0b want 1", word_err); end
    endtask

    task automatic test_saturation();
        clear_counters();
        for (int k = 0; k < 64; k++) push(CP);
        idle(1);
        checks++; if (locked8 !== 1'b1) begin fails++; $display("[TB] FAIL sat_lock: got %0b want 1", locked8); end
        push(128'd0); push(128'd0); push(128'd0); push(CP); push(128'd0); push(128'd0);
        idle(1);
        checks++; if (err_cnt8 !== 8'd255)  begin fails++; $display("[TB] FAIL sat_errs8: got %0d want 255", err_cnt8); end
        checks++; if (err_cnt !== 32'd320)  begin fails++; $display("[TB] FAIL sat_errs32: got %0d want 320", err_cnt); end
        checks++; if (word_cnt8 !== 8'd6)   begin fails++; $display("[TB] FAIL sat_words8: got %0d want 6", word_cnt8); end
        checks++; if (locked8 !== 1'b1)     begin fails++; $display("[TB] FAIL sat_locked: got %0b want 1", locked8); end
        push(128'd0);
        clr_cnt = 1'b1;
        idle(1);
        clr_cnt = 1'b0;
        checks++; if (err_cnt8 !== 8'd0)  begin fails++; $display("[TB] FAIL clr_errs8: got %0d want 0", err_cnt8); end
        checks++; if (err_cnt !== 32'd0)  begin fails++; $display("[TB] FAIL clr_errs32: got %0d want 0", err_cnt); end
        checks++; if (word_cnt !== 32'd0) begin fails++; $display("[TB] FAIL clr_words: got %0d want 0", word_cnt); end
        checks++; if (word_err !== 1'b1)  begin fails++; $display("[TB] FAIL clr_word_err: got %0b want 1", word_err); end
        checks++; if (locked !== 1'b1)    begin fails++; $display("[TB] FAIL clr_locked: got %0b want 1", locked); end
    endtask

    task automatic test_reset_mid();
        push(CP); push(CP); push(128'd0);
        idle(1);
        checks++; if (err_cnt !== 32'd64) begin fails++; $display("[TB] FAIL mid_pre_errs: got %0d want 64", err_cnt); end
        push(CP);
        #1;
        FPGA_RESETn = 1'b0;
        #1;
        checks++; if (locked !== 1'b0)    begin fails++; $display("[TB] FAIL mid_rst_locked: got %0b want 0", locked); end
        checks++; if (word_err !== 1'b0)  begin fails++; $display("[TB] FAIL mid_rst_word_err: got %0b want 0", word_err); end
        checks++; if (err_cnt !== 32'd0)  begin fails++; $display("[TB] FAIL mid_rst_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (word_cnt !== 32'd0) begin fails++; $display("[TB] FAIL mid_rst_word_cnt: got %0d want 0", word_cnt); end
        rx_valid = 1'b0;
        @(negedge clk160);
        FPGA_RESETn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_counter_wrap();
        test_prbs();
        test_mode_switch();
        test_const();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
